// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP bus-side initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssp_pkg;

    // Default depth of the SSP TX/RX FIFOs, and the cap on outstanding bytes.
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Number of idle (PSEL=0) cycles inserted after every access.
    localparam int ACCESS_GAP = 1;

    // Width needed to count 0..depth inclusive.
    function automatic int pend_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PEND_W = pend_width(FIFO_DEPTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/ssp_flush_timer.sv
// Saturating idle counter; expired_o once MAX_CNT enabled cycles pass without a clear.
// Latency: expired_o rises the cycle after the MAX_CNT-th counting edge.
// Backpressure: none; clear has priority over counting.
module ssp_flush_timer #(
    parameter int MAX_CNT = 128
) (
    input  logic PCLK,
    input  logic CLEAR_B,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(MAX_CNT + 1);
    localparam logic [W-1:0] MAX_C = W'(MAX_CNT);

    logic [W-1:0] cnt_q;

    // Count enabled cycles, stick at MAX_CNT, restart from zero on clear.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != MAX_C)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired_o = (cnt_q == MAX_C);

endmodule

// File: rtl/ssp_host.sv
// Byte stream <-> SSP FIFO bridge: writes TX bytes, drains RX on RX-full or idle timeout.
// Latency: accepted byte reaches PSEL next cycle; one access then one gap cycle, always.
// Backpressure: in_ready drops at FIFO_DEPTH outstanding, TX full or during a drain; reads wait for out_ready.
module ssp_host
    import ssp_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter int FLUSH_CYCLES = 128
) (
    input  logic       PCLK,
    input  logic       CLEAR_B,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       PSEL,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       SSPTXINTR,
    input  logic       SSPRXINTR,
    output logic       busy
);

    localparam int CNT_W = pend_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] GAP_LAST = 2'(ACCESS_GAP - 1);

    state_e           state_q;
    logic             psel_q;
    logic             pwrite_q;
    logic [7:0]       pwdata_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic [CNT_W-1:0] pending_q;   // written to the SSP, not yet read back
    logic [CNT_W-1:0] drain_q;     // reads still owed by the current drain
    logic [1:0]       gap_q;

    logic is_idle;
    logic drain_zero;
    logic load_cond;
    logic do_read;
    logic do_load;
    logic do_write;
    logic tmr_clr;
    logic tmr_en;
    logic expired;

    // IDLE decision, in priority order: finish a drain, start a drain, accept a byte.
    always_comb begin
        is_idle    = (state_q == IDLE);
        drain_zero = (drain_q == '0);
        load_cond  = SSPRXINTR || (expired && (pending_q != '0));
        do_read    = is_idle && !drain_zero && !out_valid_q;
        do_load    = is_idle && drain_zero && load_cond;
        do_write   = is_idle && drain_zero && !load_cond && in_valid &&
                     !SSPTXINTR && (pending_q < DEPTH_C);
        // Timer only runs while bytes sit in the SSP; any write or drain restarts it.
        tmr_clr    = (state_q == WRITE) || do_load || (pending_q == '0);
        tmr_en     = (pending_q != '0);
    end

    ssp_flush_timer #(
        .MAX_CNT (FLUSH_CYCLES)
    ) u_flush_timer (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (expired)
    );

    // Access sequencer: every PSEL pulse is one cycle long and followed by a gap.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            pending_q   <= '0;
            drain_q     <= '0;
            gap_q       <= 2'd0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (do_read) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b0;
                        state_q  <= READ;
                    end else if (do_load) begin
                        drain_q <= pending_q;
                    end else if (do_write) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        pwdata_q <= in_data;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    pending_q <= pending_q + CNT_W'(1);
                    psel_q    <= 1'b0;
                    gap_q     <= 2'd0;
                    state_q   <= GAP;
                end
                READ: begin
                    // out_valid is known to be 0 here: reads only launch when it is.
                    out_data_q  <= PRDATA;
                    out_valid_q <= 1'b1;
                    pending_q   <= pending_q - CNT_W'(1);
                    drain_q     <= drain_q - CNT_W'(1);
                    psel_q      <= 1'b0;
                    gap_q       <= 2'd0;
                    state_q     <= GAP;
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = do_write;
    assign PSEL      = psel_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (pending_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_ssp_host.sv
// Directed bench for ssp_host with a loopback SSP model (TX FIFO serialised into RX FIFO).
// Latency: SSP model moves one byte TX->RX every SER cycles.
// Backpressure: sink readiness driven per scenario.
module tb_ssp_host;

    localparam int SER   = 20;
    localparam int FLUSH = 128;

    logic       PCLK      = 1'b0;
    logic       CLEAR_B   = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA    = 8'h00;
    logic       SSPTXINTR = 1'b0;
    logic       SSPRXINTR = 1'b0;
    logic       busy;

    int total = 0;
    int bad   = 0;

    bit         tx_full_force = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         ser_cnt = 0;

    logic [7:0] wr_log[$];
    int         rd_at_wr[$];
    logic [7:0] rcv[$];
    int         rd_cnt     = 0;
    int         outst      = 0;
    int         max_outst  = 0;
    int         cap_viol   = 0;
    int         txw_viol   = 0;
    int         space_viol = 0;
    int         stab_viol  = 0;
    logic       prev_psel  = 1'b0;
    logic       prev_tx    = 1'b0;
    logic       cap_pwrite = 1'b0;
    logic [7:0] cap_pwdata = 8'h00;

    always #5 PCLK = ~PCLK;

    ssp_host #(
        .FIFO_DEPTH   (4),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR),
        .busy      (busy)
    );

    // SSP model, reset together with the host: accesses, then loopback shifting.
    always @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            txq.delete();
            rxq.delete();
            ser_cnt = 0;
            SSPTXINTR <= 1'b0;
            SSPRXINTR <= 1'b0;
            PRDATA    <= 8'h00;
        end else begin
            if (PSEL && PWRITE) txq.push_back(PWDATA);
            if (PSEL && !PWRITE && (rxq.size() > 0)) void'(rxq.pop_front());
            if (txq.size() > 0) begin
                if (ser_cnt == SER - 1) begin
                    rxq.push_back(txq.pop_front());
                    ser_cnt = 0;
                end else begin
                    ser_cnt++;
                end
            end
            SSPTXINTR <= (txq.size() >= 4) || tx_full_force;
            SSPRXINTR <= (rxq.size() >= 4);
            PRDATA    <= (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    // Bus monitor: logs traffic and tallies protocol rule breaks.
    always @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            outst     = 0;
            prev_psel = 1'b0;
            prev_tx   = 1'b0;
        end else begin
            if (in_ready && (outst >= 4)) cap_viol++;
            if (PSEL && prev_psel) space_viol++;
            if (PSEL && ((PWRITE !== cap_pwrite) || (PWDATA !== cap_pwdata))) stab_viol++;
            if (PSEL && PWRITE && prev_tx) txw_viol++;
            prev_tx   = SSPTXINTR;
            prev_psel = PSEL;
            if (PSEL && PWRITE) begin
                wr_log.push_back(PWDATA);
                rd_at_wr.push_back(rd_cnt);
                outst++;
            end
            if (PSEL && !PWRITE) begin
                rd_cnt++;
                outst--;
            end
            if (outst > max_outst) max_outst = outst;
            if (out_valid && out_ready) rcv.push_back(out_data);
        end
    end

    // Mid-cycle snapshot of the access attributes for the stability check.
    always @(negedge PCLK) begin
        if (PSEL) begin
            cap_pwrite = PWRITE;
            cap_pwdata = PWDATA;
        end
    end

    task automatic push(input logic [7:0] b, input int budget, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        if (ok) begin
            @(posedge PCLK);
            #1;
        end
        in_valid = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic wait_rcv(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            if (rcv.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            if (!busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        CLEAR_B   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge PCLK);
        total++; if (PSEL !== 1'b0)      begin bad++; $display("FAIL reset_psel got=%0b want=0", PSEL); end
        total++; if (PWRITE !== 1'b0)    begin bad++; $display("FAIL reset_pwrite got=%0b want=0", PWRITE); end
        total++; if (PWDATA !== 8'h00)   begin bad++; $display("FAIL reset_pwdata got=%h want=00", PWDATA); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        CLEAR_B = 1'b1;
        repeat (3) @(negedge PCLK);
        total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL post_reset_psel got=%0b want=0", PSEL); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%0b want=0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        int lat;
        int wb = wr_log.size();
        int rb = rcv.size();
        int db = rd_cnt;
        out_ready = 1'b0;
        push(8'hA5, 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_accept got=%0b want=1", ok); end
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_out_valid timeout got=%0b want=1", ok); end
        total++; if ((lat < FLUSH) || (lat > FLUSH + 8)) begin bad++; $display("FAIL single_flush_latency got=%0d want=%0d..%0d", lat, FLUSH, FLUSH + 8); end
        total++; if ((wr_log.size() <= wb) || (wr_log[wb] !== 8'hA5)) begin bad++; $display("FAIL single_pwdata got_writes=%0d want first=a5", wr_log.size() - wb); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_out_data got=%h want=a5", out_data); end
        total++; if (rd_cnt - db !== 1) begin bad++; $display("FAIL single_read_count got=%0d want=1", rd_cnt - db); end
        out_ready = 1'b1;
        wait_idle(20, ok);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%0b want=0", busy); end
        total++; if ((rcv.size() != rb + 1) || (rcv[rb] !== 8'hA5)) begin bad++; $display("FAIL single_delivered got_count=%0d want=1", rcv.size() - rb); end
    endtask

    task automatic test_burst();
        bit ok;
        bit all_ok = 1'b1;
        int wb = wr_log.size();
        int rb = rcv.size();
        int db = rd_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(8'(i + 1), 1000, ok);
            if (!ok) all_ok = 1'b0;
        end
        total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL burst_accept got=%0b want=1", all_ok); end
        wait_rcv(rb + 6, 800, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL burst_delivery timeout got=%0d want=6", rcv.size() - rb); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ((rcv.size() <= rb + i) || (rcv[rb + i] !== 8'(i + 1))) begin
                bad++;
                $display("FAIL burst_order idx=%0d got=%h want=%h", i, (rcv.size() > rb + i) ? rcv[rb + i] : 8'hxx, 8'(i + 1));
            end
        end
        total++; if (wr_log.size() - wb !== 6) begin bad++; $display("FAIL burst_write_count got=%0d want=6", wr_log.size() - wb); end
        total++; if ((rd_at_wr.size() < wb + 6) || (rd_at_wr[wb + 3] - db !== 0)) begin bad++; $display("FAIL burst_fourth_write_before_reads got_reads=%0d want=0", (rd_at_wr.size() > wb + 3) ? rd_at_wr[wb + 3] - db : -1); end
        total++; if ((rd_at_wr.size() < wb + 6) || (rd_at_wr[wb + 4] - db !== 4)) begin bad++; $display("FAIL burst_fifth_write_after_drain got_reads=%0d want=4", (rd_at_wr.size() > wb + 4) ? rd_at_wr[wb + 4] - db : -1); end
        wait_idle(50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL burst_idle got_busy=%0b want=0", busy); end
    endtask

    task automatic test_tx_full();
        bit ok;
        int wb;
        int rb = rcv.size();
        out_ready     = 1'b1;
        tx_full_force = 1'b1;
        repeat (2) @(negedge PCLK);
        wb = wr_log.size();
        push(8'h5A, 30, ok);
        total++; if (ok !== 1'b0) begin bad++; $display("FAIL txfull_accept got=%0b want=0", ok); end
        total++; if (wr_log.size() !== wb) begin bad++; $display("FAIL txfull_writes got=%0d want=0", wr_log.size() - wb); end
        tx_full_force = 1'b0;
        push(8'h5A, 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL txfull_release_accept got=%0b want=1", ok); end
        wait_rcv(rb + 1, 400, ok);
        total++; if ((rcv.size() <= rb) || (rcv[rb] !== 8'h5A)) begin bad++; $display("FAIL txfull_delivered got_count=%0d want byte=5a", rcv.size() - rb); end
        wait_idle(50, ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit all_ok = 1'b1;
        int chg = 0;
        int psel_seen = 0;
        int rb = rcv.size();
        int db;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        out_ready = 1'b0;
        db = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            push(exp_b[i], 100, ok);
            if (!ok) all_ok = 1'b0;
        end
        total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL bp_accept got=%0b want=1", all_ok); end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_first_valid timeout got=%0b want=1", ok); end
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (out_data !== 8'h11) chg++;
            if (PSEL) psel_seen++;
        end
        total++; if (rd_cnt - db !== 1) begin bad++; $display("FAIL bp_single_read got=%0d want=1", rd_cnt - db); end
        total++; if (chg !== 0) begin bad++; $display("FAIL bp_data_stable got_changes=%0d want=0", chg); end
        total++; if (psel_seen !== 0) begin bad++; $display("FAIL bp_psel_quiet got=%0d want=0", psel_seen); end
        out_ready = 1'b1;
        wait_rcv(rb + 4, 100, ok);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ((rcv.size() <= rb + i) || (rcv[rb + i] !== exp_b[i])) begin
                bad++;
                $display("FAIL bp_order idx=%0d got=%h want=%h", i, (rcv.size() > rb + i) ? rcv[rb + i] : 8'hxx, exp_b[i]);
            end
        end
        wait_idle(50, ok);
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        int rb;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h71 + i), 100, ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (PSEL && !PWRITE) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_read_seen got=%0b want=1", ok); end
        CLEAR_B = 1'b0;
        #1;
        total++; if (PSEL !== 1'b0)      begin bad++; $display("FAIL rmid_psel got=%0b want=0", PSEL); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%0b want=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy); end
        @(negedge PCLK);
        CLEAR_B = 1'b1;
        @(negedge PCLK);
        rb = rcv.size();
        push(8'h3C, 50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_new_accept got=%0b want=1", ok); end
        wait_rcv(rb + 1, 400, ok);
        total++; if ((rcv.size() <= rb) || (rcv[rb] !== 8'h3C)) begin bad++; $display("FAIL rmid_new_byte got_count=%0d want byte=3c", rcv.size() - rb); end
        wait_idle(50, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_idle got_busy=%0b want=0", busy); end
    endtask

    task automatic test_access_spacing();
        total++; if (space_viol !== 0) begin bad++; $display("FAIL spacing_psel_consecutive got=%0d want=0", space_viol); end
        total++; if (stab_viol !== 0)  begin bad++; $display("FAIL spacing_attr_stable got=%0d want=0", stab_viol); end
        total++; if (txw_viol !== 0)   begin bad++; $display("FAIL spacing_write_on_txfull got=%0d want=0", txw_viol); end
        total++; if (cap_viol !== 0)   begin bad++; $display("FAIL spacing_ready_at_cap got=%0d want=0", cap_viol); end
        total++; if (max_outst !== 4)  begin bad++; $display("FAIL spacing_max_outstanding got=%0d want=4", max_outst); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_tx_full();
        test_back_to_back();
        test_reset_mid_drain();
        test_access_spacing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ssp_host.md
Name: ssp_host

Overview:
- Bus-side initiator for the SSP peripheral. It drives PSEL/PWRITE/PWDATA into the SSP and collects PRDATA from it.
- It converts a valid/ready byte stream into SSP TX-FIFO writes and returns received bytes on a valid/ready output stream.
- The SSP exposes only FIFO-full flags, so ssp_host tracks outstanding bytes itself. It drains the RX FIFO on RX-full or after an idle timeout.

Parameters:
- FIFO_DEPTH, 4, SSP TX/RX FIFO depth; also the cap on outstanding (written-not-read) bytes.
- FLUSH_CYCLES, 128, PCLK cycles without a write, with pending>0, before the remaining bytes are drained.

Ports:
- PCLK  in  1  single clock.
- CLEAR_B  in  1  asynchronous active-low reset.
- in_valid  in  1  source byte available.
- in_data  in  8  source byte.
- in_ready  out  1  byte accepted this cycle (combinational).
- out_valid  out  1  received byte held in output register.
- out_data  out  8  received byte.
- out_ready  in  1  sink accepts out_data.
- PSEL  out  1  SSP access strobe, registered.
- PWRITE  out  1  1 = write to TX FIFO, 0 = read from RX FIFO, registered.
- PWDATA  out  8  write data, registered.
- PRDATA  in  8  SSP RX FIFO head.
- SSPTXINTR  in  1  SSP TX FIFO full.
- SSPRXINTR  in  1  SSP RX FIFO full.
- busy  out  1  pending != 0 or state != IDLE.

Behaviour:
- Reset (CLEAR_B low, async): state=IDLE; PSEL=0, PWRITE=0, PWDATA=0, out_valid=0, out_data=0; pending=0, drain_cnt=0, timer=0.
- States are IDLE, WRITE, READ, GAP. Each access lasts exactly one cycle with PSEL=1 and is always followed by one GAP cycle (PSEL=0). This lets the SSP full flags settle before the next decision.
- Output register:
  - out_valid clears on out_valid & out_ready.
  - A READ may only be launched from IDLE when out_valid=0.
- IDLE priority, evaluated each cycle:
  1. drain_cnt>0 and out_valid=0 -> READ.
  2. drain_cnt=0 and (SSPRXINTR=1, or (timer>=FLUSH_CYCLES and pending>0)) -> load drain_cnt=pending. No access this cycle.
  3. drain_cnt=0, in_valid=1, SSPTXINTR=0, pending<FIFO_DEPTH -> in_ready=1, PWDATA<=in_data, PWRITE<=1, PSEL<=1, go to WRITE.
  4. Otherwise stay in IDLE.
- in_ready=1 only in case 3; it is 0 in every other state.
- WRITE (PSEL=1, PWRITE=1): pending+1, timer cleared. Next state GAP.
- READ (PSEL=1, PWRITE=0): at the closing edge, out_data<=PRDATA, out_valid<=1, pending-1, drain_cnt-1. Next state GAP.
- GAP: PSEL<=0. Next state IDLE.
- Timer:
  - Increments each cycle, saturating at FLUSH_CYCLES.
  - Cleared on WRITE and on drain load.
  - Held at 0 while pending=0.
- Cap rule: pending never exceeds FIFO_DEPTH, so the SSP RX FIFO never overflows and SSPRXINTR implies pending=FIFO_DEPTH.
- No simultaneous increment and decrement of pending, since there is one access per cycle.
- Writes are blocked while drain_cnt>0. A new drain is never loaded while one is in progress.
- A mid-operation reset aborts any access immediately. PSEL drops asynchronously and all counts are lost; bytes already in the SSP are not tracked.

Decomposition:
- Shared package ssp_pkg holds:
  - the state enum (IDLE/WRITE/READ/GAP);
  - FIFO_DEPTH default;
  - a PEND_W = clog2(FIFO_DEPTH+1) width constant;
  - the ACCESS_GAP=1 constant.
- One sub-module: ssp_flush_timer (saturating counter with clear/enable, expired output).

Test Plan:
- Single byte: in_data=8'hA5 with the SSP serial side looped back (SSPTXD->SSPRXD) -> one write with PWDATA=A5, then ~FLUSH_CYCLES later one read; out_data=8'hA5, out_valid=1, busy falls to 0.
- Burst of 6 bytes 01..06 with loopback -> 4 writes, in_ready=0 while pending=4, drain of 4 on SSPRXINTR (out 01..04 in order), then 05, 06 written and flushed by timeout; no write ever issued while SSPTXINTR=1.
- Back-pressure: out_ready=0 during a 4-byte drain -> only one READ issued, out_data held stable, PSEL stays 0 until out_ready=1; all four bytes delivered in order.
- Access spacing: any sequence -> PSEL never high on two consecutive cycles; PWRITE and PWDATA stable while PSEL=1.
- Reset mid-drain: assert CLEAR_B=0 during READ -> PSEL=0, out_valid=0, busy=0 immediately, without waiting for a clock edge; after release, a new byte 8'h3C completes normally.
